calc_mul_arbiter: RTL and testbench

CALC_MUL_ARBITER -- requirements
Module: calc_mul_arbiter

---
 rtl/calc_pkg.sv | 31 +++
 rtl/calc_mul_seq.sv | 79 +++++++
 rtl/calc_mul_arbiter.sv | 119 +++++++++++
 tb/tb_calc_mul_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the shared-multiplier arbiter: FSM state encoding,
// default operand width, requester-id type and the round-robin grant helper.
// Build option: define CALC_MUL_SIGNED_EN for two's-complement operands.
package calc_pkg;

   localparam int CALC_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef logic req_id_t;

   // Round-robin choice between two requesters. On a tie the requester that
   // was not granted last wins; a lone valid requester always wins.
   function automatic req_id_t pick_grant(input logic v0, input logic v1,
                                          input req_id_t last);
      req_id_t g;
      if (v0 && v1) begin
         g = ~last;
      end else if (v1) begin
         g = 1'b1;
      end else begin
         g = 1'b0;
      end
      return g;
   endfunction

endpackage

// File: rtl/calc_mul_seq.sv
// Iterative shift-add multiplier datapath: one multiplier bit per step.
// 'load' captures operands and clears the bit counter; 'step' retires one
// bit; 'last' flags the step that retires the final bit.
// Build option: CALC_MUL_SIGNED_EN multiplies magnitudes and negates the
// product when the operand signs differ. Latency is the same either way.
module calc_mul_seq
   import calc_pkg::*;
#(
   parameter int WIDTH = CALC_WIDTH
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load,
   input  logic                 step,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 last,
   output logic [2*WIDTH-1:0]   product
);

   localparam int CW = $clog2(WIDTH) + 1;

   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;
   logic [CW-1:0]      count;
   logic               neg;

   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic               neg_n;

`ifdef CALC_MUL_SIGNED_EN
   // Operand magnitudes and result sign for two's-complement operands.
   always_comb begin
      mag_a = a[WIDTH-1] ? ((~a) + {{(WIDTH-1){1'b0}}, 1'b1}) : a;
      mag_b = b[WIDTH-1] ? ((~b) + {{(WIDTH-1){1'b0}}, 1'b1}) : b;
      neg_n = a[WIDTH-1] ^ b[WIDTH-1];
   end
`else
   // Unsigned operands pass straight through; the product is never negated.
   always_comb begin
      mag_a = a;
      mag_b = b;
      neg_n = 1'b0;
   end
`endif

   // Accumulator, shift registers and bit counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         count  <= '0;
         neg    <= 1'b0;
      end else if (load) begin
         acc    <= '0;
         mcand  <= {{WIDTH{1'b0}}, mag_a};
         mplier <= mag_b;
         count  <= '0;
         neg    <= neg_n;
      end else if (step) begin
         if (mplier[0]) begin
            acc <= acc + mcand;
         end
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         count  <= count + CW'(1);
      end
   end

   // Final-bit flag and sign-corrected product (held while not stepping).
   always_comb begin
      last    = step && (count == CW'(WIDTH - 1));
      product = neg ? ((~acc) + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc;
   end

endmodule

// File: rtl/calc_mul_arbiter.sv
// Two requesters share one iterative multiplier. FSM: IDLE grants one
// requester (round-robin on ties), BUSY runs WIDTH shift-add steps, DONE
// holds the result until the consumer takes it.
// Handshake: a transfer happens at a rising edge where valid and ready are
// both high; reqN_ready is combinational and only ever high in IDLE, and
// res_valid stays high with stable res_id/res_product until res_ready.
// Build option: CALC_MUL_SIGNED_EN selects two's-complement arithmetic.
module calc_mul_arbiter
   import calc_pkg::*;
#(
   parameter int WIDTH = CALC_WIDTH
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req0_valid,
   input  logic [WIDTH-1:0]     req0_a,
   input  logic [WIDTH-1:0]     req0_b,
   output logic                 req0_ready,
   input  logic                 req1_valid,
   input  logic [WIDTH-1:0]     req1_a,
   input  logic [WIDTH-1:0]     req1_b,
   output logic                 req1_ready,
   output logic                 res_valid,
   output logic                 res_id,
   output logic [2*WIDTH-1:0]   res_product,
   input  logic                 res_ready,
   output state_t               dbg_state
);

   state_t             state;
   state_t             state_n;
   req_id_t            last_grant;
   req_id_t            grant;
   req_id_t            id_q;
   logic               accept;
   logic               seq_last;
   logic [WIDTH-1:0]   op_a;
   logic [WIDTH-1:0]   op_b;
   logic [2*WIDTH-1:0] seq_product;

   // Grant choice and operand mux toward the datapath.
   always_comb begin
      grant = pick_grant(req0_valid, req1_valid, last_grant);
      op_a  = grant ? req1_a : req0_a;
      op_b  = grant ? req1_b : req0_b;
   end

   // Next-state, ready outputs and accept strobe.
   always_comb begin
      state_n    = state;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            if (!reset && (req0_valid || req1_valid)) begin
               req0_ready = (grant == 1'b0);
               req1_ready = (grant == 1'b1);
               accept     = 1'b1;
               state_n    = BUSY;
            end
         end
         BUSY: begin
            if (seq_last) begin
               state_n = DONE;
            end
         end
         DONE: begin
            if (res_ready) begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Round-robin pointer and owner id; only a real accept updates them.
   // Pointer resets to 1 so requester 0 wins the first tie.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_grant <= 1'b1;
         id_q       <= 1'b0;
      end else if (accept) begin
         last_grant <= grant;
         id_q       <= grant;
      end
   end

   calc_mul_seq #(
      .WIDTH (WIDTH)
   ) u_seq (
      .clk     (clk),
      .reset   (reset),
      .load    (accept),
      .step    (state == BUSY),
      .a       (op_a),
      .b       (op_b),
      .last    (seq_last),
      .product (seq_product)
   );

   // Result outputs are only non-zero while a result is on offer.
   always_comb begin
      res_valid   = (state == DONE);
      res_id      = (state == DONE) ? id_q : 1'b0;
      res_product = (state == DONE) ? seq_product : '0;
      dbg_state   = state;
   end

endmodule

// File: tb/tb_calc_mul_arbiter.sv
// Directed bench for calc_mul_arbiter (WIDTH=16).
module tb_calc_mul_arbiter;
   import calc_pkg::*;

   localparam int W = 16;

   logic           clk = 1'b0;
   logic           reset = 1'b0;
   logic           req0_valid = 1'b0;
   logic [W-1:0]   req0_a = '0;
   logic [W-1:0]   req0_b = '0;
   logic           req0_ready;
   logic           req1_valid = 1'b0;
   logic [W-1:0]   req1_a = '0;
   logic [W-1:0]   req1_b = '0;
   logic           req1_ready;
   logic           res_valid;
   logic           res_id;
   logic [2*W-1:0] res_product;
   logic           res_ready = 1'b0;
   state_t         dbg_state;

   int checks = 0;
   int errors = 0;
   logic [0:0] exp_q[$];

   calc_mul_arbiter #(.WIDTH(W)) dut (
      .clk         (clk),
      .reset       (reset),
      .req0_valid  (req0_valid),
      .req0_a      (req0_a),
      .req0_b      (req0_b),
      .req0_ready  (req0_ready),
      .req1_valid  (req1_valid),
      .req1_a      (req1_a),
      .req1_b      (req1_b),
      .req1_ready  (req1_ready),
      .res_valid   (res_valid),
      .res_id      (res_id),
      .res_product (res_product),
      .res_ready   (res_ready),
      .dbg_state   (dbg_state)
   );

   // Clock
   always #5 clk = ~clk;

   // ---------------- driver tasks ----------------
   task automatic idle_inputs();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      req0_a = '0; req0_b = '0;
      req1_a = '0; req1_b = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      idle_inputs();
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Counts rising edges until res_valid is seen; -1 on timeout.
   task automatic wait_res(output int n);
      n = -1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (res_valid) begin
            n = k;
            break;
         end
      end
   endtask

   // Counts negedges until any ready is high (0 = already high); -1 on timeout.
   task automatic wait_ready(output int n);
      n = -1;
      for (int k = 0; k <= 40; k++) begin
         #1;
         if (req0_ready || req1_ready) begin
            n = k;
            break;
         end
         @(negedge clk);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1 reset = 1'b1;
      @(negedge clk);
      checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL rst_ready0: got %b want 0", req0_ready); end
      checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL rst_ready1: got %b want 0", req1_ready); end
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_res_valid: got %b want 0", res_valid); end
      checks++; if (res_id !== 1'b0) begin errors++; $display("FAIL rst_res_id: got %b want 0", res_id); end
      checks++; if (res_product !== 32'h0) begin errors++; $display("FAIL rst_product: got %h want 0", res_product); end
      checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL rst_state: got %0d want %0d", dbg_state, IDLE); end
      idle_inputs();
      reset = 1'b0;
   endtask

   task automatic test_basic();
      int n;
      @(negedge clk);
      req0_a = 16'd3; req0_b = 16'd5; req0_valid = 1'b1; res_ready = 1'b1;
      #1;
      checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL basic_ready: got %b%b want 10", req0_ready, req1_ready); end
      @(posedge clk);
      #1 req0_valid = 1'b0;
      checks++; if (dbg_state !== BUSY) begin errors++; $display("FAIL basic_busy: got %0d want %0d", dbg_state, BUSY); end
      checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL basic_busy_ready: got %b%b want 00", req0_ready, req1_ready); end
      wait_res(n);
      checks++; if (n != 16) begin errors++; $display("FAIL basic_latency: got %0d want 16", n); end
      checks++; if (res_product !== 32'd15) begin errors++; $display("FAIL basic_product: got %h want %h", res_product, 32'd15); end
      checks++; if (res_id !== 1'b0) begin errors++; $display("FAIL basic_id: got %b want 0", res_id); end
      @(posedge clk);
      #1;
      checks++; if (res_valid !== 1'b0 || dbg_state !== IDLE) begin errors++; $display("FAIL basic_handshake: got valid %b state %0d want 0/%0d", res_valid, dbg_state, IDLE); end
      checks++; if (res_product !== 32'h0) begin errors++; $display("FAIL basic_product_cleared: got %h want 0", res_product); end
   endtask

   task automatic test_tie_after_reset();
      int n;
      do_reset();
      req0_a = 16'h0010; req0_b = 16'h0010; req0_valid = 1'b1;
      req1_a = 16'd2;    req1_b = 16'd7;    req1_valid = 1'b1;
      res_ready = 1'b1;
      #1;
      checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL tie_first_grant: got %b%b want 10", req0_ready, req1_ready); end
      @(posedge clk);
      #1 req0_valid = 1'b0;
      wait_res(n);
      checks++; if (n != 16) begin errors++; $display("FAIL tie_lat0: got %0d want 16", n); end
      checks++; if (res_id !== 1'b0 || res_product !== 32'h100) begin errors++; $display("FAIL tie_res0: got id %b prod %h want 0/00000100", res_id, res_product); end
      @(posedge clk);
      #1;
      checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL tie_second_ready: got %b want 1", req1_ready); end
      @(posedge clk);
      #1 req1_valid = 1'b0;
      wait_res(n);
      checks++; if (n != 16) begin errors++; $display("FAIL tie_lat1: got %0d want 16", n); end
      checks++; if (res_id !== 1'b1 || res_product !== 32'd14) begin errors++; $display("FAIL tie_res1: got id %b prod %h want 1/0000000e", res_id, res_product); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_round_robin();
      int n;
      int g;
      logic [0:0] exp_id;
      logic [2*W-1:0] exp_p;
      do_reset();
      exp_q.push_back(1'b0); exp_q.push_back(1'b1);
      exp_q.push_back(1'b0); exp_q.push_back(1'b1);
      req0_a = 16'd6; req0_b = 16'd7; req0_valid = 1'b1;
      req1_a = 16'd9; req1_b = 16'd9; req1_valid = 1'b1;
      res_ready = 1'b1;
      for (int op = 0; op < 4; op++) begin
         wait_ready(g);
         checks++; if (g != 0) begin errors++; $display("FAIL rr_gap op%0d: got %0d want 0", op, g); end
         exp_id = exp_q.pop_front();
         exp_p  = exp_id ? 32'd81 : 32'd42;
         checks++; if (req1_ready !== exp_id) begin errors++; $display("FAIL rr_grant op%0d: got %b want %b", op, req1_ready, exp_id); end
         @(posedge clk);
         wait_res(n);
         checks++; if (n != 16) begin errors++; $display("FAIL rr_latency op%0d: got %0d want 16", op, n); end
         checks++; if (res_id !== exp_id) begin errors++; $display("FAIL rr_id op%0d: got %b want %b", op, res_id, exp_id); end
         checks++; if (res_product !== exp_p) begin errors++; $display("FAIL rr_product op%0d: got %h want %h", op, res_product, exp_p); end
         @(posedge clk);
      end
      #1 idle_inputs();
   endtask

   task automatic test_hold_and_withdraw();
      int n;
      // pointer now says requester 1 was granted last
      req0_a = 16'd100; req0_b = 16'd200; req0_valid = 1'b1; res_ready = 1'b0;
      #1;
      checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL hold_grant: got %b want 1", req0_ready); end
      @(posedge clk);
      #1 req0_valid = 1'b0;
      req1_a = 16'd1; req1_b = 16'd1; req1_valid = 1'b1;
      wait_res(n);
      checks++; if (n != 16) begin errors++; $display("FAIL hold_latency: got %0d want 16", n); end
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         @(negedge clk);
         checks++;
         if (res_valid !== 1'b1 || res_id !== 1'b0 || res_product !== 32'd20000 ||
             req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_cycle%0d: got v%b id%b p%h rdy%b%b want v1 id0 p%h rdy00",
                     c, res_valid, res_id, res_product, req0_ready, req1_ready, 32'd20000);
         end
      end
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      checks++; if (dbg_state !== IDLE || res_valid !== 1'b0) begin errors++; $display("FAIL hold_release: got state %0d v%b want %0d v0", dbg_state, res_valid, IDLE); end
      checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL hold_no_early_accept: got %b want 1", req1_ready); end
      // requester 1 withdraws before its grant is taken
      req1_valid = 1'b0;
      @(posedge clk);
      #1;
      checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL withdraw_idle: got %0d want %0d", dbg_state, IDLE); end
      req0_a = 16'd2; req0_b = 16'd2; req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin errors++; $display("FAIL withdraw_rr: got %b%b want 01", req0_ready, req1_ready); end
      @(posedge clk);
      #1 idle_inputs();
      wait_res(n);
      checks++; if (res_id !== 1'b1 || res_product !== 32'd1) begin errors++; $display("FAIL withdraw_res: got id %b prod %h want 1/00000001", res_id, res_product); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_busy();
      logic seen;
      req0_a = 16'd3; req0_b = 16'd5; req0_valid = 1'b1; res_ready = 1'b1;
      @(posedge clk);
      #1 req0_valid = 1'b0;
      repeat (7) @(posedge clk);
      @(negedge clk);
      req0_valid = 1'b1;
      reset = 1'b1;
      #1;
      checks++; if (res_valid !== 1'b0 || dbg_state !== IDLE) begin errors++; $display("FAIL rb_reset: got v%b state %0d want v0 %0d", res_valid, dbg_state, IDLE); end
      checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL rb_ready_in_reset: got %b want 0", req0_ready); end
      req0_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (res_valid !== 1'b0 || dbg_state !== IDLE) seen = 1'b1;
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rb_no_result: got activity %b want 0", seen); end
   endtask

   task automatic test_zero_single();
      int n;
      req1_a = 16'd0; req1_b = 16'hFFFF; req1_valid = 1'b1; res_ready = 1'b1;
      #1;
      checks++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin errors++; $display("FAIL zero_grant: got %b%b want 01", req0_ready, req1_ready); end
      @(posedge clk);
      #1 req1_valid = 1'b0;
      wait_res(n);
      checks++; if (n != 16) begin errors++; $display("FAIL zero_latency: got %0d want 16", n); end
      checks++; if (res_product !== 32'h0 || res_id !== 1'b1) begin errors++; $display("FAIL zero_res: got id %b prod %h want 1/0", res_id, res_product); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_sign_mode();
      int n;
      logic [2*W-1:0] exp_p;
`ifdef CALC_MUL_SIGNED_EN
      exp_p = 32'hFFFF_FFF1;
`else
      exp_p = 32'h0004_FFF1;
`endif
      req0_a = 16'hFFFD; req0_b = 16'd5; req0_valid = 1'b1; res_ready = 1'b1;
      @(posedge clk);
      #1 req0_valid = 1'b0;
      wait_res(n);
      checks++; if (n != 16) begin errors++; $display("FAIL sign_latency: got %0d want 16", n); end
      checks++; if (res_product !== exp_p) begin errors++; $display("FAIL sign_product: got %h want %h", res_product, exp_p); end
      @(posedge clk);
      #1 idle_inputs();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_tie_after_reset();
      test_round_robin();
      test_hold_and_withdraw();
      test_reset_busy();
      test_zero_single();
      test_sign_mode();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
